// File: rtl/bsg_then_ready_link_concentrator_rr.sv
// N-way then_ready link concentrator (burst-limited round-robin) and tag-based distributor.
// Optional perf counters and their ports are enabled with `define BSG_CONC_PERF_COUNTERS_EN.
module bsg_then_ready_link_concentrator_rr #(
    parameter int width_p        = 32,
    parameter int num_in_p       = 4,
    parameter int max_burst_p    = 1,
    parameter int rev_fifo_els_p = 2,
    localparam int tag_width_lp  = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [num_in_p-1:0]             chan_en_i,
    input  logic [num_in_p-1:0]             in_v_i,
    input  logic [num_in_p*width_p-1:0]     in_data_i,
    output logic [num_in_p-1:0]             in_yumi_o,
    output logic                            conc_v_o,
    output logic [tag_width_lp+width_p-1:0] conc_data_o,
    input  logic                            conc_ready_and_i,
    input  logic                            conc_v_i,
    input  logic [tag_width_lp+width_p-1:0] conc_data_i,
    output logic                            conc_yumi_o,
    output logic [num_in_p-1:0]             out_v_o,
    output logic [num_in_p*width_p-1:0]     out_data_o,
    input  logic [num_in_p-1:0]             out_yumi_i
`ifdef BSG_CONC_PERF_COUNTERS_EN
    ,
    output logic [num_in_p*32-1:0]          perf_grant_o,
    output logic [31:0]                     perf_stall_o,
    output logic [15:0]                     perf_drop_o
`endif
);

    // state    | meaning
    // ARB_IDLE | no eligible channel last cycle; burst count is 0
    // ARB_HOLD | ptr_r holds last granted channel, burst_r its consecutive grant count
    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

    localparam logic [7:0] max_burst_lp = 8'(max_burst_p);
    localparam int pw_lp = $clog2(rev_fifo_els_p) + 1;

    arb_state_e state_r, state_n;
    logic [tag_width_lp-1:0] ptr_r, ptr_n, grant_idx;
    logic [tag_width_lp:0]   cand_sum;
    logic [7:0]              burst_r, burst_n;
    logic [num_in_p-1:0]     elig;
    logic                    reuse, found, grant_any, can_grant;
    logic [width_p-1:0]      in_data_arr [num_in_p];

    logic                            v0_r, v1_r, deq, enq;
    logic [tag_width_lp+width_p-1:0] d0_r, d1_r, enq_word;

    for (genvar i = 0; i < num_in_p; i++) begin : g_in_split
        assign in_data_arr[i] = in_data_i[i*width_p +: width_p];
    end

    assign elig      = in_v_i & chan_en_i;
    assign can_grant = ~v1_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ARB_IDLE;
            ptr_r   <= '0;
            burst_r <= '0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            burst_r <= burst_n;
        end
    end

    always_comb begin
        reuse     = elig[ptr_r] & ((state_r == ARB_IDLE) | (burst_r < max_burst_lp));
        found     = 1'b0;
        grant_idx = ptr_r;
        cand_sum  = '0;
        if (!reuse) begin
            // wrap-around search starting just after the last grant
            for (int k = 1; k <= num_in_p; k++) begin
                cand_sum = {1'b0, ptr_r} + (tag_width_lp+1)'(k);
                if (cand_sum >= (tag_width_lp+1)'(num_in_p))
                    cand_sum = cand_sum - (tag_width_lp+1)'(num_in_p);
                if (!found && elig[cand_sum[tag_width_lp-1:0]]) begin
                    found     = 1'b1;
                    grant_idx = cand_sum[tag_width_lp-1:0];
                end
            end
        end
        grant_any = can_grant & (reuse | found) & reset_n_i;

        state_n = state_r;
        ptr_n   = ptr_r;
        burst_n = burst_r;
        if (elig == '0) begin
            state_n = ARB_IDLE;
            burst_n = '0;
        end else if (grant_any) begin
            state_n = ARB_HOLD;
            ptr_n   = grant_idx;
            burst_n = reuse ? burst_r + 8'd1 : 8'd1;
        end
    end

    always_comb begin
        in_yumi_o = '0;
        if (grant_any)
            in_yumi_o[grant_idx] = 1'b1;
    end

    // two-slot output stage: d0 is the presented word, d1 the skid
    assign enq_word    = {grant_idx, in_data_arr[grant_idx]};
    assign enq         = grant_any;
    assign deq         = v0_r & conc_ready_and_i;
    assign conc_v_o    = v0_r;
    assign conc_data_o = d0_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
            d0_r <= '0;
            d1_r <= '0;
        end else if (deq) begin
            if (v1_r) begin
                d0_r <= d1_r;
                v1_r <= 1'b0;
            end else begin
                v0_r <= enq;
                if (enq) d0_r <= enq_word;
            end
        end else if (enq) begin
            if (!v0_r) begin
                v0_r <= 1'b1;
                d0_r <= enq_word;
            end else begin
                v1_r <= 1'b1;
                d1_r <= enq_word;
            end
        end
    end

    logic [tag_width_lp-1:0] rev_tag;
    logic [width_p-1:0]      rev_payload;
    logic [num_in_p-1:0]     fifo_full;
    logic                    tag_ok, chan_on, rev_enq, rev_drop;

    assign rev_tag     = conc_data_i[width_p +: tag_width_lp];
    assign rev_payload = conc_data_i[width_p-1:0];
    assign tag_ok      = {1'b0, rev_tag} < (tag_width_lp+1)'(num_in_p);
    assign chan_on     = tag_ok & chan_en_i[rev_tag];
    // a pop on a full FIFO frees the slot for a same-cycle enqueue
    assign conc_yumi_o = reset_n_i & conc_v_i
                       & (~chan_on | ~fifo_full[rev_tag] | out_yumi_i[rev_tag]);
    assign rev_enq     = conc_yumi_o & chan_on;
    assign rev_drop    = conc_yumi_o & ~chan_on;

    for (genvar i = 0; i < num_in_p; i++) begin : g_rev
        logic [pw_lp-1:0]   wr_r, rd_r;
        logic [width_p-1:0] mem_r [rev_fifo_els_p];
        logic               push, pop, empty;

        assign empty        = (wr_r == rd_r);
        assign fifo_full[i] = ((wr_r ^ rd_r) == {1'b1, {(pw_lp-1){1'b0}}});
        assign push         = rev_enq & (rev_tag == tag_width_lp'(i));
        assign pop          = out_yumi_i[i] & ~empty;
        assign out_v_o[i]   = ~empty;
        assign out_data_o[i*width_p +: width_p] = mem_r[rd_r[pw_lp-2:0]];

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                wr_r <= '0;
                rd_r <= '0;
                for (int e = 0; e < rev_fifo_els_p; e++) mem_r[e] <= '0;
            end else begin
                if (push) begin
                    mem_r[wr_r[pw_lp-2:0]] <= rev_payload;
                    wr_r <= wr_r + pw_lp'(1);
                end
                if (pop) rd_r <= rd_r + pw_lp'(1);
            end
        end
    end

`ifdef BSG_CONC_PERF_COUNTERS_EN
    logic [31:0] stall_r;
    logic [15:0] drop_r;

    for (genvar i = 0; i < num_in_p; i++) begin : g_perf_grant
        logic [31:0] cnt_r;
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)
                cnt_r <= '0;
            else if (in_yumi_o[i] && cnt_r != 32'hFFFF_FFFF)
                cnt_r <= cnt_r + 32'd1;
        end
        assign perf_grant_o[i*32 +: 32] = cnt_r;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_r <= '0;
            drop_r  <= '0;
        end else begin
            if (v0_r && !conc_ready_and_i && stall_r != 32'hFFFF_FFFF)
                stall_r <= stall_r + 32'd1;
            if (rev_drop && drop_r != 16'hFFFF)
                drop_r <= drop_r + 16'd1;
        end
    end

    assign perf_stall_o = stall_r;
    assign perf_drop_o  = drop_r;
`else
    logic unused_drop;
    assign unused_drop = rev_drop;
`endif

endmodule

// File: tb/tb_bsg_then_ready_link_concentrator_rr.sv
// Directed bench for the round-robin link concentrator: one DUT with max_burst 1, one with max_burst 3.
module tb_bsg_then_ready_link_concentrator_rr;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    chan_en, in_v, out_yumi;
    logic [N*W-1:0]  in_data;
    logic            ready, cv_in;
    logic [TW+W-1:0] cd_in;

    logic [N-1:0]    yumi_a, outv_a, yumi_b, outv_b;
    logic            cv_a, cyumi_a, cv_b, cyumi_b;
    logic [TW+W-1:0] cdata_a, cdata_b;
    logic [N*W-1:0]  outd_a, outd_b;
`ifdef BSG_CONC_PERF_COUNTERS_EN
    logic [N*32-1:0] pgrant_a, pgrant_b;
    logic [31:0]     pstall_a, pstall_b;
    logic [15:0]     pdrop_a, pdrop_b;
`endif

    int checks = 0;
    int errors = 0;

    bsg_then_ready_link_concentrator_rr #(.width_p(W), .num_in_p(N), .max_burst_p(1), .rev_fifo_els_p(2)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .chan_en_i(chan_en), .in_v_i(in_v), .in_data_i(in_data),
        .in_yumi_o(yumi_a), .conc_v_o(cv_a), .conc_data_o(cdata_a), .conc_ready_and_i(ready),
        .conc_v_i(cv_in), .conc_data_i(cd_in), .conc_yumi_o(cyumi_a),
        .out_v_o(outv_a), .out_data_o(outd_a), .out_yumi_i(out_yumi)
`ifdef BSG_CONC_PERF_COUNTERS_EN
        , .perf_grant_o(pgrant_a), .perf_stall_o(pstall_a), .perf_drop_o(pdrop_a)
`endif
    );

    bsg_then_ready_link_concentrator_rr #(.width_p(W), .num_in_p(N), .max_burst_p(3), .rev_fifo_els_p(2)) dut_b3 (
        .clk_i(clk), .reset_n_i(reset_n), .chan_en_i(chan_en), .in_v_i(in_v), .in_data_i(in_data),
        .in_yumi_o(yumi_b), .conc_v_o(cv_b), .conc_data_o(cdata_b), .conc_ready_and_i(ready),
        .conc_v_i(cv_in), .conc_data_i(cd_in), .conc_yumi_o(cyumi_b),
        .out_v_o(outv_b), .out_data_o(outd_b), .out_yumi_i(out_yumi)
`ifdef BSG_CONC_PERF_COUNTERS_EN
        , .perf_grant_o(pgrant_b), .perf_stall_o(pstall_b), .perf_drop_o(pdrop_b)
`endif
    );

    function automatic logic [W-1:0] pay(int ch);
        return 32'h1020_3040 + 32'(ch) * 32'h0101_0101;
    endfunction

    function automatic logic [TW+W-1:0] word(int ch);
        return {TW'(ch), pay(ch)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        chan_en = 4'hF; in_v = 4'hF; ready = 1'b1; cv_in = 1'b1;
        cd_in = {2'd1, 32'h5555_0000}; out_yumi = '0;
        #1;
        checks++;
        if (cv_a !== 1'b0 || yumi_a !== 4'b0 || cyumi_a !== 1'b0 || outv_a !== 4'b0) begin
            errors++;
            $display("FAIL reset_state: got conc_v=%b yumi=%b conc_yumi=%b out_v=%b, expected 0 0000 0 0000",
                     cv_a, yumi_a, cyumi_a, outv_a);
        end
        cv_in = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_tags[6] = '{0, 1, 2, 3, 0, 1};
        in_v = 4'hF; chan_en = 4'hF; ready = 1'b1;
        do_reset();
        #1;
        checks++;
        if (yumi_a !== 4'b0001 || cv_a !== 1'b0) begin
            errors++;
            $display("FAIL rr_first_grant: got yumi=%b conc_v=%b, expected 0001 0", yumi_a, cv_a);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (cv_a !== 1'b1 || cdata_a !== word(exp_tags[k])) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got v=%b data=%h, expected v=1 data=%h",
                         k, cv_a, cdata_a, word(exp_tags[k]));
            end
        end
    endtask

    task automatic test_burst();
        int exp_tags[9] = '{1, 1, 1, 2, 2, 2, 1, 1, 1};
        in_v = 4'b0110; chan_en = 4'hF; ready = 1'b1;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (cv_b !== 1'b1 || cdata_b !== word(exp_tags[k])) begin
                errors++;
                $display("FAIL burst_seq[%0d]: got v=%b data=%h, expected v=1 data=%h",
                         k, cv_b, cdata_b, word(exp_tags[k]));
            end
        end
    endtask

    task automatic test_chan_disable();
        int exp_tags[6] = '{0, 1, 3, 0, 1, 3};
        in_v = 4'hF; chan_en = 4'b1011; ready = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (cv_a !== 1'b1 || cdata_a !== word(exp_tags[k]) || yumi_a[2] !== 1'b0) begin
                errors++;
                $display("FAIL disable_seq[%0d]: got v=%b data=%h yumi=%b, expected v=1 data=%h yumi[2]=0",
                         k, cv_a, cdata_a, yumi_a, word(exp_tags[k]));
            end
        end
        in_v = 4'b0;
        cv_in = 1'b1; cd_in = {2'd2, 32'h0000_00AB};
        #1;
        checks++;
        if (cyumi_a !== 1'b1) begin
            errors++;
            $display("FAIL drop_accept: got conc_yumi=%b, expected 1", cyumi_a);
        end
        @(negedge clk);
        cv_in = 1'b0;
        checks++;
        if (outv_a !== 4'b0) begin
            errors++;
            $display("FAIL drop_not_delivered: got out_v=%b, expected 0000", outv_a);
        end
`ifdef BSG_CONC_PERF_COUNTERS_EN
        checks++;
        if (pdrop_a !== 16'd1) begin
            errors++;
            $display("FAIL perf_drop: got %0d, expected 1", pdrop_a);
        end
`endif
    endtask

    task automatic test_rev_full();
        logic       st_v   [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic [7:0] st_d   [8] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00};
        logic       st_pop [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        logic       ex_yumi[8] = '{1, 1, 0, 0, 1, 0, 0, 0};
        logic       ex_ov  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] ex_head[8] = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h00};
        chan_en = 4'hF; in_v = 4'b0;
        for (int s = 0; s < 8; s++) begin
            cv_in = st_v[s]; cd_in = {2'd3, 24'h0, st_d[s]}; out_yumi = {st_pop[s], 3'b000};
            #1;
            checks++;
            if (cyumi_a !== ex_yumi[s] || outv_a[3] !== ex_ov[s]
                || (ex_ov[s] && outd_a[3*W +: W] !== {24'h0, ex_head[s]})) begin
                errors++;
                $display("FAIL rev_full[%0d]: got conc_yumi=%b out_v3=%b head=%h, expected %b %b %h",
                         s, cyumi_a, outv_a[3], outd_a[3*W +: W], ex_yumi[s], ex_ov[s], ex_head[s]);
            end
            @(negedge clk);
        end
        cv_in = 1'b0; out_yumi = '0;
    endtask

    task automatic test_stall();
        int grants = 0;
        in_v = 4'hF; chan_en = 4'hF; ready = 1'b1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            grants += $countones(yumi_a);
            @(negedge clk);
            checks++;
            if (cv_a !== 1'b1 || cdata_a !== word(1)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b data=%h, expected v=1 data=%h", w, cv_a, cdata_a, word(1));
            end
        end
        checks++;
        if (grants !== 1) begin
            errors++;
            $display("FAIL stall_grants: got %0d, expected 1", grants);
        end
`ifdef BSG_CONC_PERF_COUNTERS_EN
        checks++;
        if (pstall_a !== 32'd5) begin
            errors++;
            $display("FAIL perf_stall: got %0d, expected 5", pstall_a);
        end
`endif
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cdata_a !== word(2)) begin
            errors++;
            $display("FAIL stall_drain_a: got %h, expected %h", cdata_a, word(2));
        end
        @(negedge clk);
        checks++;
        if (cdata_a !== word(3)) begin
            errors++;
            $display("FAIL stall_drain_b: got %h, expected %h", cdata_a, word(3));
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        cv_in = 1'b1; cd_in = {2'd0, 32'h0};
        #1;
        checks++;
        if (cv_a !== 1'b0 || yumi_a !== 4'b0 || cyumi_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got conc_v=%b yumi=%b conc_yumi=%b, expected 0 0000 0", cv_a, yumi_a, cyumi_a);
        end
        cv_in = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (yumi_a !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_ptr: got yumi=%b, expected 0001", yumi_a);
        end
        @(negedge clk);
        checks++;
        if (cv_a !== 1'b1 || cdata_a !== word(0)) begin
            errors++;
            $display("FAIL reset_mid_first: got v=%b data=%h, expected v=1 data=%h", cv_a, cdata_a, word(0));
        end
    endtask

    initial begin
        chan_en = '0; in_v = '0; out_yumi = '0; ready = 1'b0; cv_in = 1'b0; cd_in = '0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = pay(i);
        test_reset();
        test_round_robin();
        test_burst();
        test_chan_disable();
        test_rev_full();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $fatal(1, "timeout");
    end
endmodule
